cuckoo_l3_table_loader: RTL
===========================

// Module: cuckoo_l3_table_loader
// PURPOSE
//  Write-side companion to the L3 cuckoo lookup pipeline. It inserts 26-bit L3 pattern entries into the pattern RAM (T3).
//  It also inserts 9-bit pattern pointers into the split index RAM, with T1 at {1'b0,h1} and T2 at {1'b1,h2}.
//  Bounded cuckoo eviction resolves collisions. It sits between the host/control register path and the write ports of the index and pattern RAMs.
// PARAMETERS
//  MAX_KICKS  16  max evictions per insert before FAIL (1..255)
//  PTR_W      9   pattern pointer width; pointer 0 reserved = empty
//  HASH_W     10  bucket address width per table
//  ENTRY_W    26  pattern entry width
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  cmd_valid    in   1        insert request
//  cmd_ready    out  1        high only in IDLE
//  cmd_h1       in   10       T1 bucket of new key
//  cmd_h2       in   10       T2 bucket of new key
//  cmd_entry    in   26       pattern entry for T3
//  rsp_valid    out  1        1-cycle pulse, insert finished
//  rsp_status   out  2        0 OK, 1 FULL, 2 FAIL
//  rsp_ptr      out  9        OK: allocated ptr; FAIL: orphaned ptr; FULL: 0
//  t12_we       out  1        index RAM write strobe
//  t12_addr     out  11       {sel,bucket}; sel 0=T1, 1=T2
//  t12_din      out  9        pointer written
//  t3_we        out  1        pattern RAM write strobe
//  t3_addr      out  9        pattern slot
//  t3_din       out  26       entry written
//  busy         out  1        ~IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, next_ptr=1, T1/T2 valid bitmaps cleared.
//   All outputs 0 except cmd_ready=1.
//  Internal shadows:
//   - occ1/occ2: 1024-bit valid maps.
//   - sh1/sh2: 1024x9 pointer copies of T1/T2.
//   - key RAM: 512x20 holding {h1,h2} per ptr.
//   - Shadow RAMs are not reset; the valid bits gate them.
//  FSM: IDLE -> ALLOC -> LOOK -> PLACE -> (KICK -> LOOK)* -> RESP -> IDLE.
//  IDLE: cmd_valid & cmd_ready latches h1/h2/entry (cycle 0).
//  ALLOC (cycle 1):
//   - If next_ptr==512, go to RESP with FULL; nothing is written.
//   - Otherwise t3_we=1, t3_addr=next_ptr, t3_din=entry, key[next_ptr]={h1,h2}, cur=next_ptr, next_ptr++, side=T1.
//  LOOK: reads the occ bit and shadow of cur's bucket on the current side. Shadow read takes 1 cycle.
//  PLACE:
//   - t12_we=1 writes cur to the bucket and updates the shadow and occ bit.
//   - If the bucket was empty, go to RESP with OK.
//   - If occupied and kicks<MAX_KICKS: victim=old ptr, kicks++, go to KICK.
//   - If occupied and kicks==MAX_KICKS: the write is suppressed; go to RESP with FAIL, rsp_ptr=cur.
//  First attempt order: T1[h1] is tried, and only if occupied is T2[h2] tried before any eviction.
//   - That is, the first occupied T1 bucket leads to LOOK on T2 without a write, which does not count as a kick.
//   - Eviction starts only when both are full; it evicts from T2, then alternates sides.
//  KICK: reads key[victim] and sets cur=victim with the alternate side and bucket. 1 cycle.
//  Uncontested insert: rsp_valid at cycle 4 after acceptance.
//  t12_we and t3_we are never high in the same cycle. Every write strobe lasts exactly 1 cycle.
//  Same-bucket collision (h1 and h2 both map to a bucket holding cur's own old copy) cannot occur; the tables are disjoint.
//  A FAIL leaves the tables consistent. The orphan ptr's T3 slot stays allocated and is not reclaimed.
//  Reset mid-insert: the FSM aborts to IDLE with no further writes. Partial RAM writes are not undone; the host re-initialises.
//  cmd inputs are ignored while busy. No deletion is supported.
// CONFIGURATION
//  CUCKOO_L3_LOADER_STATS_EN defined: adds the following outputs.
//   - stat_ins[15:0]: OK count.
//   - stat_kicks[15:0]: total evictions.
//   - stat_fail[7:0]: FAIL plus FULL count.
//   - All three saturate, are cleared by reset, and increment in the RESP cycle (kicks in KICK).
//  Not defined: the ports and counters are absent, and the core behaviour is identical.
// TESTING
//  - Reset, then cmd h1=5 h2=9 entry=0x0ABCDEF:
//    - cycle 1: t3_we with addr 1.
//    - cycle 3: t12_we with addr 0x005, din 1.
//    - cycle 4: rsp OK, ptr 1.
//  - Second cmd h1=5 h2=7: t12 write to addr 0x407 (T2) with din 2; OK, no kick.
//  - Third cmd h1=5 h2=7:
//    - T2[7] is evicted and ptr3 is written to 0x407.
//    - ptr2 is written to T1[5], which evicts ptr1.
//    - ptr1 is written to 0x409; OK with kicks=2.
//  - MAX_KICKS=1, with keys filling T1[3] and T2[4] and a cycle that needs more than 1 kick -> rsp FAIL with rsp_ptr = the orphan; stat_fail=1.
//  - Insert 511 keys with distinct buckets -> all OK; the 512th -> FULL, ptr 0, and no t3_we or t12_we.
//  - Assert rst_n low during a KICK -> outputs go 0 immediately; after release cmd_ready=1 and next_ptr restarts at 1.

Source files
------------

// File: rtl/cuckoo_l3_table_loader_if.sv
// Bundles the insert command, the insert response and the two RAM write
// ports of the L3 cuckoo table loader. The host side uses the master modport;
// the loader itself uses the slave modport.
interface cuckoo_l3_table_loader_if #(
    parameter int PTR_W   = 9,
    parameter int HASH_W  = 10,
    parameter int ENTRY_W = 26
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [HASH_W-1:0]  cmd_h1;
    logic [HASH_W-1:0]  cmd_h2;
    logic [ENTRY_W-1:0] cmd_entry;

    logic               rsp_valid;
    logic [1:0]         rsp_status;
    logic [PTR_W-1:0]   rsp_ptr;

    logic               t12_we;
    logic [HASH_W:0]    t12_addr;
    logic [PTR_W-1:0]   t12_din;

    logic               t3_we;
    logic [PTR_W-1:0]   t3_addr;
    logic [ENTRY_W-1:0] t3_din;

    logic               busy;

    modport master (
        output cmd_valid, cmd_h1, cmd_h2, cmd_entry,
        input  cmd_ready, rsp_valid, rsp_status, rsp_ptr,
        input  t12_we, t12_addr, t12_din, t3_we, t3_addr, t3_din, busy
    );

    modport slave (
        input  cmd_valid, cmd_h1, cmd_h2, cmd_entry,
        output cmd_ready, rsp_valid, rsp_status, rsp_ptr,
        output t12_we, t12_addr, t12_din, t3_we, t3_addr, t3_din, busy
    );
endinterface

// File: rtl/cuckoo_l3_table_loader.sv
// Write-side loader for the L3 cuckoo lookup. Allocates a pattern slot in T3,
// then places the new pointer into T1 (bucket h1) or T2 (bucket h2), falling
// back to bounded cuckoo eviction when both candidate buckets are taken.
// Shadow copies of T1/T2 and a per-pointer key store let the loader find
// victims without reading the real index RAM.
// Optional feature macro: CUCKOO_L3_LOADER_STATS_EN adds saturating
// statistics outputs (stat_ins, stat_kicks, stat_fail).
module cuckoo_l3_table_loader #(
    parameter int MAX_KICKS = 16,
    parameter int PTR_W     = 9,
    parameter int HASH_W    = 10,
    parameter int ENTRY_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    cuckoo_l3_table_loader_if.slave bus
`ifdef CUCKOO_L3_LOADER_STATS_EN
    ,
    output logic [15:0] stat_ins,
    output logic [15:0] stat_kicks,
    output logic [7:0]  stat_fail
`endif
);

    localparam int NBUCKET = 1 << HASH_W;
    localparam int NPTR    = 1 << PTR_W;
    localparam logic [PTR_W:0] PTR_LIMIT_C  = (PTR_W+1)'(NPTR);
    localparam logic [PTR_W:0] PTR_FIRST_C  = (PTR_W+1)'(1);
    localparam logic [7:0]     KICK_LIMIT_C = 8'(MAX_KICKS);
    localparam logic [1:0]     ST_OK   = 2'd0;
    localparam logic [1:0]     ST_FULL = 2'd1;
    localparam logic [1:0]     ST_FAIL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALLOC = 3'd1,
        S_LOOK  = 3'd2,
        S_PLACE = 3'd3,
        S_KICK  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // What the LOOK cycle decided for the PLACE cycle to act on.
    typedef enum logic [1:0] {
        OC_DONE = 2'd0,
        OC_TRY2 = 2'd1,
        OC_KICK = 2'd2,
        OC_FAIL = 2'd3
    } outcome_t;

    state_t             state_r;
    outcome_t           outcome_r;
    logic [PTR_W:0]     next_ptr_r;
    logic               full_r;
    logic [HASH_W-1:0]  h1_r;
    logic [HASH_W-1:0]  h2_r;
    logic [PTR_W-1:0]   cur_r;
    logic [PTR_W-1:0]   new_ptr_r;
    logic [PTR_W-1:0]   victim_r;
    logic               side_r;
    logic               first_r;
    logic [7:0]         kicks_r;
    logic [NBUCKET-1:0] occ1_r;
    logic [NBUCKET-1:0] occ2_r;

    logic [PTR_W-1:0]    sh1_r [NBUCKET];
    logic [PTR_W-1:0]    sh2_r [NBUCKET];
    logic [2*HASH_W-1:0] key_r [NPTR];

    logic              accept_s;
    logic              alloc_we_s;
    logic              place_we_s;
    logic              look_hit_s;
    logic [HASH_W-1:0] look_bucket_s;
    logic [PTR_W-1:0]  look_old_s;
    outcome_t          look_outcome_s;

    // Bucket probe of the current side and the placement decision
    always_comb begin
        accept_s   = (state_r == S_IDLE) && bus.cmd_valid;
        alloc_we_s = accept_s && (next_ptr_r != PTR_LIMIT_C);
        if (side_r) begin
            look_bucket_s = h2_r;
            look_hit_s    = occ2_r[h2_r];
            look_old_s    = sh2_r[h2_r];
        end else begin
            look_bucket_s = h1_r;
            look_hit_s    = occ1_r[h1_r];
            look_old_s    = sh1_r[h1_r];
        end
        // A fresh key that finds T1 taken tries T2 before any eviction.
        if (!look_hit_s) begin
            look_outcome_s = OC_DONE;
        end else if (first_r && !side_r) begin
            look_outcome_s = OC_TRY2;
        end else if (kicks_r < KICK_LIMIT_C) begin
            look_outcome_s = OC_KICK;
        end else begin
            look_outcome_s = OC_FAIL;
        end
        place_we_s = (state_r == S_LOOK) &&
                     ((look_outcome_s == OC_DONE) || (look_outcome_s == OC_KICK));
    end

    // Shadow tables and key store; occupancy bits gate them so no reset needed
    always_ff @(posedge clk) begin
        if (alloc_we_s) begin
            key_r[next_ptr_r[PTR_W-1:0]] <= {bus.cmd_h1, bus.cmd_h2};
        end
        if (place_we_s) begin
            if (side_r) begin
                sh2_r[look_bucket_s] <= cur_r;
            end else begin
                sh1_r[look_bucket_s] <= cur_r;
            end
        end
    end

    // Insert FSM with registered handshake and RAM write outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            outcome_r      <= OC_DONE;
            next_ptr_r     <= PTR_FIRST_C;
            full_r         <= 1'b0;
            h1_r           <= '0;
            h2_r           <= '0;
            cur_r          <= '0;
            new_ptr_r      <= '0;
            victim_r       <= '0;
            side_r         <= 1'b0;
            first_r        <= 1'b0;
            kicks_r        <= 8'd0;
            occ1_r         <= '0;
            occ2_r         <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= 2'd0;
            bus.rsp_ptr    <= '0;
            bus.t12_we     <= 1'b0;
            bus.t12_addr   <= '0;
            bus.t12_din    <= '0;
            bus.t3_we      <= 1'b0;
            bus.t3_addr    <= '0;
            bus.t3_din     <= '0;
        end else begin
            // Strobes and response are single-cycle pulses by default.
            bus.rsp_valid  <= 1'b0;
            bus.rsp_status <= 2'd0;
            bus.rsp_ptr    <= '0;
            bus.t12_we     <= 1'b0;
            bus.t12_addr   <= '0;
            bus.t12_din    <= '0;
            bus.t3_we      <= 1'b0;
            bus.t3_addr    <= '0;
            bus.t3_din     <= '0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r       <= S_ALLOC;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        h1_r          <= bus.cmd_h1;
                        h2_r          <= bus.cmd_h2;
                        side_r        <= 1'b0;
                        first_r       <= 1'b1;
                        kicks_r       <= 8'd0;
                        full_r        <= !alloc_we_s;
                        cur_r         <= next_ptr_r[PTR_W-1:0];
                        new_ptr_r     <= next_ptr_r[PTR_W-1:0];
                        if (alloc_we_s) begin
                            bus.t3_we   <= 1'b1;
                            bus.t3_addr <= next_ptr_r[PTR_W-1:0];
                            bus.t3_din  <= bus.cmd_entry;
                            next_ptr_r  <= next_ptr_r + PTR_FIRST_C;
                        end
                    end
                end
                S_ALLOC: begin
                    if (full_r) begin
                        state_r        <= S_RESP;
                        bus.rsp_valid  <= 1'b1;
                        bus.rsp_status <= ST_FULL;
                    end else begin
                        state_r <= S_LOOK;
                    end
                end
                S_LOOK: begin
                    state_r   <= S_PLACE;
                    outcome_r <= look_outcome_s;
                    if (place_we_s) begin
                        bus.t12_we   <= 1'b1;
                        bus.t12_addr <= {side_r, look_bucket_s};
                        bus.t12_din  <= cur_r;
                        if (side_r) begin
                            occ2_r[look_bucket_s] <= 1'b1;
                        end else begin
                            occ1_r[look_bucket_s] <= 1'b1;
                        end
                    end
                    if (look_outcome_s == OC_KICK) begin
                        victim_r <= look_old_s;
                        kicks_r  <= kicks_r + 8'd1;
                    end
                end
                S_PLACE: begin
                    case (outcome_r)
                        OC_DONE: begin
                            state_r        <= S_RESP;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_status <= ST_OK;
                            bus.rsp_ptr    <= new_ptr_r;
                        end
                        OC_TRY2: begin
                            state_r <= S_LOOK;
                            side_r  <= 1'b1;
                            first_r <= 1'b0;
                        end
                        OC_KICK: begin
                            state_r <= S_KICK;
                        end
                        OC_FAIL: begin
                            state_r        <= S_RESP;
                            bus.rsp_valid  <= 1'b1;
                            bus.rsp_status <= ST_FAIL;
                            bus.rsp_ptr    <= cur_r;
                        end
                        default: begin
                            state_r       <= S_IDLE;
                            bus.cmd_ready <= 1'b1;
                            bus.busy      <= 1'b0;
                        end
                    endcase
                end
                S_KICK: begin
                    // The displaced pointer moves to its bucket in the other table.
                    state_r      <= S_LOOK;
                    {h1_r, h2_r} <= key_r[victim_r];
                    cur_r        <= victim_r;
                    side_r       <= ~side_r;
                    first_r      <= 1'b0;
                end
                S_RESP: begin
                    state_r       <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state_r       <= S_IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CUCKOO_L3_LOADER_STATS_EN
    // Saturating insert, eviction and failure counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ins   <= 16'd0;
            stat_kicks <= 16'd0;
            stat_fail  <= 8'd0;
        end else begin
            if ((state_r == S_KICK) && (stat_kicks != 16'hFFFF)) begin
                stat_kicks <= stat_kicks + 16'd1;
            end else begin
                stat_kicks <= stat_kicks;
            end
            if ((state_r == S_RESP) && (bus.rsp_status == ST_OK) && (stat_ins != 16'hFFFF)) begin
                stat_ins <= stat_ins + 16'd1;
            end else begin
                stat_ins <= stat_ins;
            end
            if ((state_r == S_RESP) && (bus.rsp_status != ST_OK) && (stat_fail != 8'hFF)) begin
                stat_fail <= stat_fail + 8'd1;
            end else begin
                stat_fail <= stat_fail;
            end
        end
    end
`endif

endmodule
